// File: rtl/mem_stage_pkg.sv
// Shared types and lane helpers for the MEM stage: size/state encodings,
// byte enables, store-lane replication and load extraction/extension.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    return (raw == 2'b11) ? MEM_WORD : mem_size_t'(raw);
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
    case (size)
      MEM_HALF: return lane[0];
      MEM_WORD: return lane != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input mem_size_t size, input logic [1:0] lane);
    case (size)
      MEM_BYTE: return 4'b0001 << lane;
      MEM_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input mem_size_t size, input logic [31:0] data);
    case (size)
      MEM_BYTE: return {4{data[7:0]}};
      MEM_HALF: return {2{data[15:0]}};
      default:  return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input mem_size_t size, input logic sgn,
                                              input logic [1:0] lane, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_BYTE: return {{24{sgn & b[7]}}, b};
      MEM_HALF: return {{16{sgn & h[15]}}, h};
      default:  return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ext_ram.sv
// Byte-enabled 32-bit data RAM: synchronous write, asynchronous read,
// asynchronous clear of every word on reset.
module data_ram_be #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_comb rdata = mem[addr];

endmodule

// File: rtl/mem_stage_ext.sv
// MIPS MEM stage with sub-word access, alignment check and configurable
// access latency; the output registers double as the MEM/WB register.
module mem_stage_ext
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      validInput,
  input  logic                      memToRegInput,
  input  logic                      regWriteInput,
  input  logic                      memWriteInput,
  input  logic                      memReadInput,
  input  logic [1:0]                memSizeInput,
  input  logic                      memSignedInput,
  input  logic [31:0]               aluResultInput,
  input  logic [31:0]               memWriteDataInput,
  input  logic [REG_ADDR_WIDTH-1:0] regWriteAddressInput,
  output logic                      stallOutput,
  output logic                      validOutput,
  output logic                      memToRegOutput,
  output logic                      regWriteOutput,
  output logic [31:0]               dataMemoryOutput,
  output logic [31:0]               aluResultOutput,
  output logic [REG_ADDR_WIDTH-1:0] regWriteAddressOutput,
  output logic                      misalignedOutput
);

  localparam logic       MULTI    = (LATENCY > 1);
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  mem_state_t            state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic                  capture;
  mem_size_t             size;
  logic [1:0]            lane;
  logic                  memop, misaligned, ram_we;
  logic [31:0]           ram_rdata, load_data;

  assign size       = decode_size(memSizeInput);
  assign lane       = aluResultInput[1:0];
  assign memop      = validInput & (memReadInput | memWriteInput);
  assign misaligned = memop & is_misaligned(size, lane);
  assign ram_we     = capture & memop & memWriteInput & ~misaligned;
  assign load_data  = (memop & ~memWriteInput & ~misaligned)
                      ? load_extend(size, memSignedInput, lane, ram_rdata) : '0;

  data_ram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .be    (byte_enable(size, lane)),
    .addr  (aluResultInput[ADDR_WIDTH+1:2]),
    .wdata (store_lanes(size, memWriteDataInput)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    stallOutput = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (memop & MULTI & ~misaligned) begin
          stallOutput = 1'b1;
          state_nxt   = BUSY;
          cnt_nxt     = CNT_INIT;
        end else begin
          capture = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 3'd0) begin
          stallOutput = 1'b1;
          cnt_nxt     = cnt - 3'd1;
        end else begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall cycles present a bubble downstream so WB never sees an instruction twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validOutput           <= 1'b0;
      memToRegOutput        <= 1'b0;
      regWriteOutput        <= 1'b0;
      dataMemoryOutput      <= '0;
      aluResultOutput       <= '0;
      regWriteAddressOutput <= '0;
      misalignedOutput      <= 1'b0;
    end else if (capture) begin
      validOutput           <= validInput;
      memToRegOutput        <= validInput & memToRegInput;
      regWriteOutput        <= validInput & regWriteInput & ~misaligned;
      dataMemoryOutput      <= load_data;
      aluResultOutput       <= validInput ? aluResultInput : '0;
      regWriteAddressOutput <= validInput ? regWriteAddressInput : '0;
      misalignedOutput      <= misaligned;
    end else begin
      validOutput           <= 1'b0;
      memToRegOutput        <= 1'b0;
      regWriteOutput        <= 1'b0;
      dataMemoryOutput      <= '0;
      aluResultOutput       <= '0;
      regWriteAddressOutput <= '0;
      misalignedOutput      <= 1'b0;
    end
  end

endmodule
